muldiv_seq: RTL

Iterative multiply/divide sequencer for the RV32M extension, sitting beside the execute-stage ALU. It accepts one M-op from the ID/EX register and holds the pipeline while it runs. It uses shift-add multiply and restoring divide, one bit per cycle, then presents a registered result for one cycle so EX/MEM captures it in place of `ALUResultE`. The hazard unit ORs `BusyE` into its stall for F/D/E.

---
 rtl/muldiv_seq.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative RV32M multiply/divide sequencer beside the EX-stage ALU.
//            It uses shift-add multiply and restoring divide, one bit per
//            cycle, and presents a registered result for one cycle (DoneE) so
//            EX/MEM captures it in place of the ALU result.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   XLEN           operand/result width and iteration count. Mirrors
//                  riscv_pkg::XLEN (32) and must be a power of two.
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   StartE         valid M-op in EX
//   FlushE         abort the current op; has priority over StartE
//   MulDivOpE[2:0] funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcAE          rs1 (multiplicand / dividend)
//   SrcBE          rs2 (multiplier / divisor)
//   BusyE          stall request to the hazard unit (combinational)
//   DoneE          result valid this cycle
//   MulDivResultE  registered result, held until the next completion
// Configuration
//   MULDIV_FASTPATH_EN  when defined, divide-by-zero, signed divide overflow
//                       and multiply by zero go IDLE -> DONE in one cycle.
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] MulDivResultE
);
    localparam int              c_CW     = $clog2(XLEN);
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_MIN    = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2:0]      c_OP_MUL    = 3'd0;
    localparam logic [2:0]      c_OP_MULH   = 3'd1;
    localparam logic [2:0]      c_OP_MULHSU = 3'd2;
    localparam logic [2:0]      c_OP_DIV    = 3'd4;
    localparam logic [2:0]      c_OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_op;
    logic            r_neg;       // final result must be negated
    logic            r_special;   // special case: use r_spec_res
    logic [XLEN-1:0] r_spec_res;
    logic [XLEN-1:0] r_hi;        // product upper half / partial remainder
    logic [XLEN-1:0] r_lo;        // multiplier -> product low / dividend -> quotient
    logic [XLEN-1:0] r_opb;       // multiplicand or divisor magnitude
    logic [XLEN-1:0] r_result;

    // ---------------- start-edge decode ----------------
    logic            w_is_div, w_a_signed, w_b_signed, w_sa, w_sb;
    logic            w_div0, w_ovf, w_mul0, w_spec_hit;
    logic [XLEN-1:0] w_mag_a, w_mag_b, w_spec_res;

    assign w_is_div   = MulDivOpE[2];
    assign w_a_signed = (MulDivOpE == c_OP_MULH) | (MulDivOpE == c_OP_MULHSU) |
                        (MulDivOpE == c_OP_DIV)  | (MulDivOpE == c_OP_REM);
    assign w_b_signed = (MulDivOpE == c_OP_MULH) | (MulDivOpE == c_OP_DIV) |
                        (MulDivOpE == c_OP_REM);
    assign w_sa       = w_a_signed & SrcAE[XLEN-1];
    assign w_sb       = w_b_signed & SrcBE[XLEN-1];
    assign w_mag_a    = w_sa ? -SrcAE : SrcAE;
    assign w_mag_b    = w_sb ? -SrcBE : SrcBE;
    assign w_div0     = w_is_div & (SrcBE == '0);
    // Only the signed divide ops have B signed, so w_b_signed selects DIV/REM here.
    assign w_ovf      = w_is_div & w_b_signed & (SrcAE == c_MIN) & (&SrcBE);
    assign w_mul0     = ~w_is_div & ((SrcAE == '0) | (SrcBE == '0));
    assign w_spec_hit = w_div0 | w_ovf | w_mul0;

    // Architectural results for the corner cases; funct3[1] selects remainder.
    always_comb begin
        w_spec_res = '0;
        if (w_div0)
            w_spec_res = MulDivOpE[1] ? SrcAE : '1;
        else if (w_ovf)
            w_spec_res = MulDivOpE[1] ? '0 : SrcAE;
    end

    // ---------------- one iteration step ----------------
    logic [XLEN:0]   w_sum, w_shift, w_trial;
    logic [XLEN-1:0] w_hi_nx, w_lo_nx;

    assign w_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opb}) : {1'b0, r_hi};
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, r_opb};

    always_comb begin
        if (r_op[2]) begin
            // Restoring divide: keep the trial difference when it is non-negative.
            w_hi_nx = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], ~w_trial[XLEN]};
        end else begin
            // Shift-add multiply: the carry of the add becomes the new top bit.
            w_hi_nx = w_sum[XLEN:1];
            w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
        end
    end

    // ---------------- sign fix-up and select (last RUN edge) ----------------
    logic [2*XLEN-1:0] w_prod, w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_final;

    assign w_prod     = {w_hi_nx, w_lo_nx};
    assign w_prod_fix = r_neg ? -w_prod : w_prod;
    assign w_quo_fix  = r_neg ? -w_lo_nx : w_lo_nx;
    assign w_rem_fix  = r_neg ? -w_hi_nx : w_hi_nx;

    always_comb begin
        w_final = '0;
        case (r_op)
            c_OP_MUL:             w_final = w_prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:     w_final = w_prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:           w_final = w_quo_fix;
            default:              w_final = w_rem_fix;
        endcase
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg      <= 1'b0;
            r_special  <= 1'b0;
            r_spec_res <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opb      <= '0;
            r_result   <= '0;
        end else if (FlushE) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (StartE) begin
                        r_op       <= MulDivOpE;
                        r_cnt      <= '0;
                        r_hi       <= '0;
                        r_lo       <= w_is_div ? w_mag_a : w_mag_b;
                        r_opb      <= w_is_div ? w_mag_b : w_mag_a;
                        r_neg      <= (MulDivOpE == c_OP_REM) ? w_sa : (w_sa ^ w_sb);
                        r_special  <= w_spec_hit;
                        r_spec_res <= w_spec_res;
`ifdef MULDIV_FASTPATH_EN
                        if (w_spec_hit) begin
                            r_state  <= S_DONE;
                            r_result <= w_spec_res;
                        end else begin
                            r_state  <= S_RUN;
                        end
`else
                        r_state    <= S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state  <= S_DONE;
                        r_result <= r_special ? r_spec_res : w_final;
                    end
                end
                // StartE is ignored here: the completing instruction is still in EX.
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign BusyE         = rst & (((r_state == S_IDLE) & StartE & ~FlushE) |
                                  (r_state == S_RUN));
    assign DoneE         = (r_state == S_DONE);
    assign MulDivResultE = r_result;

endmodule
`default_nettype wire
